// File: rtl/doodle_pkg.sv
// Shared types and default geometry/physics constants for the doodle player-physics stage.
package doodle_pkg;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_DOODLE_W = 16;
  localparam int DEF_DOODLE_H = 16;
  localparam int DEF_X_START  = 312;
  localparam int DEF_Y_START  = 400;
  localparam int DEF_JUMP_VEL = 12;
  localparam int DEF_MAX_FALL = 10;
  localparam int DEF_X_STEP   = 2;

  localparam int POS_W  = 10;  // screen coordinate width
  localparam int PSUM_W = 11;  // signed intermediate for position math
  localparam int VEL_W  = 6;   // signed vertical velocity width

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RISING,
    ST_FALLING,
    ST_DEAD
  } state_e;

endpackage

// File: rtl/tick_edge.sv
// Turns a divided clock level into a one-clk tick pulse, registered so the pulse
// lands one cycle after the level is first sampled high.
module tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic tick
);

  logic prev_q, prev_d;
  logic armed_q, armed_d;
  logic tick_q, tick_d;

  // armed_q suppresses a tick when the level is already high as reset releases.
  always_comb begin
    prev_d  = level;
    armed_d = 1'b1;
    tick_d  = level & ~prev_q & armed_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/doodle_motion.sv
// Doodle position/velocity/state machine driven by gravity and move ticks.
// Define DOODLE_WRAP_EN for horizontal wrap-around; otherwise x clamps to the screen.
module doodle_motion
  import doodle_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int DOODLE_W = DEF_DOODLE_W,
  parameter int DOODLE_H = DEF_DOODLE_H,
  parameter int X_START  = DEF_X_START,
  parameter int Y_START  = DEF_Y_START,
  parameter int JUMP_VEL = DEF_JUMP_VEL,
  parameter int MAX_FALL = DEF_MAX_FALL,
  parameter int X_STEP   = DEF_X_STEP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    gravity_clk,
  input  logic                    doodle_clk,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    start,
  input  logic                    on_platform,
  output logic [POS_W-1:0]        doodle_x,
  output logic [POS_W-1:0]        doodle_y,
  output logic signed [VEL_W-1:0] doodle_vel,
  output logic                    falling,
  output logic                    dead
);

  localparam logic signed [PSUM_W-1:0] Y_FLOOR  = PSUM_W'(SCREEN_H - DOODLE_H);
  localparam logic signed [PSUM_W-1:0] X_MAX    = PSUM_W'(SCREEN_W - DOODLE_W);
  localparam logic signed [PSUM_W-1:0] X_STEP_S = PSUM_W'(X_STEP);
  localparam logic signed [VEL_W:0]    VEL_HI   = (VEL_W+1)'(MAX_FALL);
  localparam logic signed [VEL_W:0]    VEL_LO   = (VEL_W+1)'(-JUMP_VEL);
  localparam logic signed [VEL_W-1:0]  VEL_JUMP = VEL_W'(-JUMP_VEL);
  localparam logic [POS_W-1:0]         X_INIT   = POS_W'(X_START);
  localparam logic [POS_W-1:0]         Y_INIT   = POS_W'(Y_START);

  logic g_tick, d_tick;

  tick_edge u_gravity_edge (
    .clk   (clk),
    .rst   (rst),
    .level (gravity_clk),
    .tick  (g_tick)
  );

  tick_edge u_doodle_edge (
    .clk   (clk),
    .rst   (rst),
    .level (doodle_clk),
    .tick  (d_tick)
  );

  state_e                  state_q, state_d;
  logic [POS_W-1:0]        x_q, x_d, y_q, y_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;

  logic signed [PSUM_W-1:0] y_sum, x_sum;
  logic signed [VEL_W:0]    vel_inc;
  logic signed [VEL_W-1:0]  vel_grav;
  logic [POS_W-1:0]         y_grav, x_move;
  logic                     moving;

  // Shared arithmetic for the gravity and move updates.
  always_comb begin
    y_sum   = $signed({1'b0, y_q}) + $signed({{(PSUM_W-VEL_W){vel_q[VEL_W-1]}}, vel_q});
    vel_inc = $signed({vel_q[VEL_W-1], vel_q}) + (VEL_W+1)'(1);
    if (vel_inc > VEL_HI)      vel_grav = VEL_HI[VEL_W-1:0];
    else if (vel_inc < VEL_LO) vel_grav = VEL_LO[VEL_W-1:0];
    else                       vel_grav = vel_inc[VEL_W-1:0];
    y_grav = (y_sum < 0) ? '0 : y_sum[POS_W-1:0];

    if (btn_right) x_sum = $signed({1'b0, x_q}) + X_STEP_S;
    else           x_sum = $signed({1'b0, x_q}) - X_STEP_S;
`ifdef DOODLE_WRAP_EN
    if (x_sum >= X_MAX)  x_move = '0;
    else if (x_sum < 0)  x_move = X_MAX[POS_W-1:0];
    else                 x_move = x_sum[POS_W-1:0];
`else
    if (x_sum > X_MAX)   x_move = X_MAX[POS_W-1:0];
    else if (x_sum < 0)  x_move = '0;
    else                 x_move = x_sum[POS_W-1:0];
`endif
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vel_d   = vel_q;
    moving  = (state_q == ST_RISING) || (state_q == ST_FALLING);

    unique case (state_q)
      ST_IDLE, ST_DEAD: begin
        if (start) begin
          state_d = ST_RISING;
          x_d     = X_INIT;
          y_d     = Y_INIT;
          vel_d   = VEL_JUMP;
        end
      end
      ST_RISING: begin
        if (g_tick) begin
          y_d   = y_grav;
          vel_d = vel_grav;
          if (!vel_grav[VEL_W-1]) state_d = ST_FALLING;
        end
      end
      ST_FALLING: begin
        if (g_tick) begin
          if (on_platform) begin
            // A bounce replaces the move for this tick.
            state_d = ST_RISING;
            vel_d   = VEL_JUMP;
          end else if (y_sum >= Y_FLOOR) begin
            state_d = ST_DEAD;
            y_d     = Y_FLOOR[POS_W-1:0];
            vel_d   = vel_grav;
          end else begin
            y_d   = y_grav;
            vel_d = vel_grav;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (moving && d_tick && (btn_right ^ btn_left)) x_d = x_move;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= X_INIT;
      y_q     <= Y_INIT;
      vel_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
    end
  end

  assign doodle_x   = x_q;
  assign doodle_y   = y_q;
  assign doodle_vel = vel_q;
  assign falling    = (state_q == ST_FALLING);
  assign dead       = (state_q == ST_DEAD);

endmodule

// File: doc/doodle_motion.md
# doodle_motion

Doodle player-physics stage, directly downstream of the clock divider. Runs on the 50 MHz master clock. Consumes the divided `gravity_clk` and `doodle_clk` levels as rising-edge tick enables, not as clocks. Produces the doodle's screen position, vertical velocity and alive/dead status for the collision, render and score stages.

## Interface
- `SCREEN_W`, 640: horizontal pixel count.
- `SCREEN_H`, 480: vertical pixel count; y grows downward.
- `DOODLE_W`, 16: sprite width in pixels.
- `DOODLE_H`, 16: sprite height in pixels.
- `X_START`, 312: x loaded on reset and on start.
- `Y_START`, 400: y loaded on reset and on start.
- `JUMP_VEL`, 12: upward speed applied on a bounce, in px per gravity tick.
- `MAX_FALL`, 10: terminal downward velocity.
- `X_STEP`, 2: px moved per doodle tick.
- `clk` in 1: 50 MHz master clock; every flop is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `gravity_clk` in 1: divided level; each rising edge is one gravity tick.
- `doodle_clk` in 1: divided level; each rising edge is one move tick.
- `btn_left` in 1: move left while held.
- `btn_right` in 1: move right while held.
- `start` in 1: leave IDLE or DEAD.
- `on_platform` in 1: collision stage says the feet overlap a platform.
- `doodle_x` out 10: left edge of the sprite.
- `doodle_y` out 10: top edge of the sprite.
- `doodle_vel` out 6: signed vertical velocity; negative means up.
- `falling` out 1: high in FALLING.
- `dead` out 1: high in DEAD.

## Operation
- **Tick detection:**
  - Register each divided level into `*_prev`.
  - `tick = level & ~prev`, which gives one `clk`-wide pulse per rising edge.
- **States:** IDLE, RISING, FALLING, DEAD.
  - IDLE → RISING on `start`; load `vel = -JUMP_VEL`.
  - RISING → FALLING on the gravity tick where the updated `vel >= 0`.
  - FALLING → RISING on a gravity tick with `on_platform = 1`:
    - load `vel = -JUMP_VEL`;
    - y is unchanged on that tick (the bounce has priority over the move).
  - FALLING → DEAD on a gravity tick where `y + vel >= SCREEN_H - DOODLE_H`; y is clamped to `SCREEN_H - DOODLE_H`.
  - DEAD → RISING on `start`; reload `X_START`, `Y_START` and `vel = -JUMP_VEL`.
  - `on_platform` is ignored outside FALLING.
- **Gravity tick in RISING or FALLING (no bounce):**
  - `y <= y + sext(vel)`, clamped at 0 (the top).
  - Then `vel <= min(vel + 1, MAX_FALL)`.
- **Move tick:**
  - Only in RISING or FALLING.
  - `btn_right` alone: `x += X_STEP`. `btn_left` alone: `x -= X_STEP`. Both or neither: hold.
  - Edge behaviour follows `DOODLE_WRAP_EN` (see Configuration).
- **Arithmetic:**
  - Position math in 11-bit signed intermediates; results truncated to 10 bits only after the clamp or wrap.
  - `vel` saturates in [-JUMP_VEL, MAX_FALL].
- **Both ticks in the same cycle:** x and y both update; they are independent.
- **IDLE and DEAD:** positions are frozen.

## Timing
- **Reset values:** state IDLE, `doodle_x = X_START`, `doodle_y = Y_START`, `doodle_vel = 0`, `falling = 0`, `dead = 0`, both `*_prev = 0`.
- **Output latency:** outputs update on the `clk` edge after the one where `clk` samples a divided input newly high, i.e. 1 cycle of latency.
- **`start`:** acted on in the cycle it is sampled high.
- **`rst` mid-jump:** overrides everything that cycle.
- **Divided clock already high when reset releases:** no tick, because `prev` is loaded with the live level from the first post-reset cycle onward.
- **`on_platform`:** sampled only in tick cycles; no setup requirement beyond a single `clk`.

## Configuration
- `DOODLE_WRAP_EN` defined: horizontal wrap-around.
  - Stepping past `SCREEN_W - DOODLE_W` gives `x = 0`.
  - Stepping below 0 gives `x = SCREEN_W - DOODLE_W`.
- Undefined: x clamps to [0, `SCREEN_W - DOODLE_W`].

## Structure
- **Package `doodle_pkg`:**
  - state enum;
  - screen and sprite size constants;
  - velocity width (6).
- **Sub-module `tick_edge`:**
  - level in, 1-cycle pulse out, synchronous `rst`;
  - instantiated twice (gravity, doodle).

## Test plan
- **Reset, start, first tick:** reset, pulse `start`, one gravity edge → `doodle_y = 388`, `doodle_vel = -11`, state RISING.
- **Apex:** 12 gravity ticks after start → `vel = 0`, `falling = 1`; y has peaked at 400 − 78 = 322.
- **Bounce:** FALLING with `vel = 5`, `on_platform = 1` on a tick → y unchanged, `vel = -12`, `falling = 0`.
- **Death:**
  - y = 460, vel = 6, tick → `doodle_y = 464`, `dead = 1`;
  - further ticks leave outputs frozen;
  - `start` → x = 312, y = 400.
- **Right edge:** x = 622, `btn_right` held, one doodle tick → x = 0 with `DOODLE_WRAP_EN`, x = 624 without.
- **Simultaneous input:** both buttons held plus a coincident gravity and doodle tick → x held, y updated; then assert `rst` mid-jump → all outputs at reset values next cycle.
